// File: rtl/ddr_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter in front of the DDR port: round-robin AR
// arbitration, master index tagged into the slave ID MSB, in-order R routing.
module ddr_rd_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 6,
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [ID_W+ADDR_W+12:0]        m0_ar,
  input  logic                           m0_arvalid,
  output logic                           m0_arready,
  output logic [ID_W+DATA_W+2:0]         m0_r,
  output logic                           m0_rvalid,
  input  logic                           m0_rready,
  input  logic [ID_W+ADDR_W+12:0]        m1_ar,
  input  logic                           m1_arvalid,
  output logic                           m1_arready,
  output logic [ID_W+DATA_W+2:0]         m1_r,
  output logic                           m1_rvalid,
  input  logic                           m1_rready,
  output logic [ID_W+ADDR_W+13:0]        s_ar,
  output logic                           s_arvalid,
  input  logic                           s_arready,
  input  logic [ID_W+DATA_W+3:0]         s_r,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  output logic [$clog2(MAX_OUTST):0]     o_outst,
  output logic                           o_err
);

  localparam int AR_W  = ID_W + ADDR_W + 13;
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  logic                  rr_ptr;
  logic [MAX_OUTST-1:0]  order_q;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic                  slot_free;
  logic                  grant;
  logic                  winner;
  logic [AR_W-1:0]       win_ar;
  logic                  head;
  logic                  nonempty;
  logic                  r_hs;
  logic                  r_pop;
  logic                  err_set;

  always_comb begin
    slot_free  = 1'b0;
    grant      = 1'b0;
    winner     = 1'b0;
    win_ar     = '0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    nonempty   = 1'b0;
    head       = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    s_rready   = 1'b0;
    r_hs       = 1'b0;
    r_pop      = 1'b0;
    err_set    = 1'b0;

    slot_free  = !s_arvalid || s_arready;
    // rstn gating keeps arready low while reset is held, not just after release
    grant      = rstn && slot_free && (o_outst < CNT_W'(MAX_OUTST))
                 && (m0_arvalid || m1_arvalid);
    winner     = (m0_arvalid && m1_arvalid) ? rr_ptr : m1_arvalid;
    win_ar     = winner ? m1_ar : m0_ar;
    m0_arready = grant && !winner;
    m1_arready = grant && winner;

    // The order FIFO holds exactly one entry per in-flight burst, so its
    // occupancy is the outstanding count itself.
    nonempty   = (o_outst != '0);
    head       = order_q[rd_ptr];
    m0_rvalid  = s_rvalid && nonempty && !head;
    m1_rvalid  = s_rvalid && nonempty && head;
    s_rready   = nonempty && (head ? m1_rready : m0_rready);
    r_hs       = s_rvalid && s_rready;
    r_pop      = r_hs && s_r[0];
    err_set    = (s_rvalid && !nonempty)
                 || (r_hs && (s_r[ID_W+DATA_W+3] != head));
  end

  assign m0_r = s_r[ID_W+DATA_W+2:0];
  assign m1_r = s_r[ID_W+DATA_W+2:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_ar      <= '0;
      s_arvalid <= 1'b0;
      rr_ptr    <= 1'b0;
      order_q   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_outst   <= '0;
      o_err     <= 1'b0;
    end else begin
      if (grant) begin
        s_ar            <= {winner, win_ar};
        s_arvalid       <= 1'b1;
        rr_ptr          <= !winner;
        order_q[wr_ptr] <= winner;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end else if (s_arready) begin
        s_arvalid <= 1'b0;
      end

      if (r_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({grant, r_pop})
        2'b10:   o_outst <= o_outst + CNT_W'(1);
        2'b01:   o_outst <= o_outst - CNT_W'(1);
        default: o_outst <= o_outst;
      endcase

      if (err_set) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter: expected AR beats and R routing order are
// queued as requests are driven and checked as the DUT hands them off.
module tb_ddr_rd_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 64;
  localparam int ID_W      = 6;
  localparam int MAX_OUTST = 4;
  localparam int AR_W      = ID_W + ADDR_W + 13;
  localparam int SAR_W     = AR_W + 1;
  localparam int R_W       = ID_W + DATA_W + 3;
  localparam int SR_W      = R_W + 1;
  localparam int CNT_W     = $clog2(MAX_OUTST) + 1;

  logic              clk;
  logic              rstn;
  logic [AR_W-1:0]   m0_ar, m1_ar;
  logic              m0_arvalid, m1_arvalid;
  logic              m0_arready, m1_arready;
  logic [R_W-1:0]    m0_r, m1_r;
  logic              m0_rvalid, m1_rvalid;
  logic              m0_rready, m1_rready;
  logic [SAR_W-1:0]  s_ar;
  logic              s_arvalid;
  logic              s_arready;
  logic [SR_W-1:0]   s_r;
  logic              s_rvalid;
  logic              s_rready;
  logic [CNT_W-1:0]  o_outst;
  logic              o_err;

  logic [ID_W:0]     rid_b;
  logic [DATA_W-1:0] rdata_b;
  logic [1:0]        rresp_b;
  logic              rlast_b;

  assign s_r = {rid_b, rdata_b, rresp_b, rlast_b};

  int unsigned       vectors;
  int unsigned       miscompares;
  logic [SAR_W-1:0]  ar_q[$];
  bit                rt_q[$];
  bit                err_exp;

  ddr_rd_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ID_W      (ID_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .m0_ar      (m0_ar),
    .m0_arvalid (m0_arvalid),
    .m0_arready (m0_arready),
    .m0_r       (m0_r),
    .m0_rvalid  (m0_rvalid),
    .m0_rready  (m0_rready),
    .m1_ar      (m1_ar),
    .m1_arvalid (m1_arvalid),
    .m1_arready (m1_arready),
    .m1_r       (m1_r),
    .m1_rvalid  (m1_rvalid),
    .m1_rready  (m1_rready),
    .s_ar       (s_ar),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_r        (s_r),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .o_outst    (o_outst),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AR_W-1:0] mk_ar(input logic [ID_W-1:0] id,
                                            input logic [ADDR_W-1:0] a,
                                            input logic [7:0] len);
    return {id, a, len, 3'd3, 2'b01};
  endfunction

  task automatic beat(input logic [ID_W:0] rid, input logic [DATA_W-1:0] d, input logic last);
    rid_b    = rid;
    rdata_b  = d;
    rresp_b  = 2'b00;
    rlast_b  = last;
    s_rvalid = 1'b1;
  endtask

  task automatic idle();
    s_rvalid = 1'b0;
  endtask

  // One clock: entered at posedge+1 with inputs driven. g/w state whether a
  // grant is expected this cycle and to which master.
  task automatic step(input bit g, input bit w, input bit seterr);
    logic [SAR_W-1:0] ea;
    bit hd;
    bit hs;
    #1;
    chk("m0_arready", m0_arready, g && !w);
    chk("m1_arready", m1_arready, g && w);
    chk("o_err_pre", o_err, err_exp);
    if (s_arvalid && s_arready) begin
      if (ar_q.size() == 0) chk("s_ar_unexpected", s_arvalid, 1'b0);
      else begin
        ea = ar_q.pop_front();
        chk("s_ar", s_ar, ea);
      end
    end else if (s_arvalid && ar_q.size() != 0) begin
      chk("s_ar_hold", s_ar, ar_q[0]);
    end
    if (s_rvalid) begin
      if (rt_q.size() == 0) begin
        chk("s_rready_empty", s_rready, 1'b0);
        chk("m0_rvalid_empty", m0_rvalid, 1'b0);
        chk("m1_rvalid_empty", m1_rvalid, 1'b0);
      end else begin
        hd = rt_q[0];
        hs = hd ? m1_rready : m0_rready;
        chk("m0_rvalid", m0_rvalid, !hd);
        chk("m1_rvalid", m1_rvalid, hd);
        chk("m_r", hd ? m1_r : m0_r, {rid_b[ID_W-1:0], rdata_b, rresp_b, rlast_b});
        chk("s_rready", s_rready, hs);
        if (hs && rlast_b) void'(rt_q.pop_front());
      end
    end else begin
      chk("m0_rvalid_idle", m0_rvalid, 1'b0);
      chk("m1_rvalid_idle", m1_rvalid, 1'b0);
    end
    if (g) begin
      ea = {w, w ? m1_ar : m0_ar};
      ar_q.push_back(ea);
      rt_q.push_back(w);
    end
    @(posedge clk);
    #1;
    if (seterr) err_exp = 1'b1;
    chk("o_outst", o_outst, rt_q.size());
    chk("o_err", o_err, err_exp);
    if (g) chk("s_arvalid_lat", s_arvalid, 1'b1);
  endtask

  task automatic do_reset();
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    s_rvalid   = 1'b0;
    rstn       = 1'b0;
    ar_q.delete();
    rt_q.delete();
    err_exp = 1'b0;
    #2;
    chk("rst_s_arvalid", s_arvalid, 1'b0);
    chk("rst_m0_arready", m0_arready, 1'b0);
    chk("rst_m1_arready", m1_arready, 1'b0);
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m1_rvalid", m1_rvalid, 1'b0);
    chk("rst_s_rready", s_rready, 1'b0);
    chk("rst_o_outst", o_outst, 0);
    chk("rst_o_err", o_err, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      beat({rt_q[0], 6'(i + 1)}, 64'hD000 + 64'(i), 1'b1);
      step(0, 0, 0);
    end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    err_exp     = 1'b0;
    rstn        = 1'b1;
    m0_ar = '0; m1_ar = '0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    s_arready = 1'b1;
    s_rvalid = 1'b0;
    rid_b = '0; rdata_b = '0; rresp_b = '0; rlast_b = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single m0 read, 4 beats
    m0_ar = mk_ar(6'd5, 32'h100, 8'd3);
    m0_arvalid = 1'b1;
    step(1, 0, 0);
    chk("s_arid", s_ar[SAR_W-1 -: 7], 7'h05);
    m0_arvalid = 1'b0;
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      beat({1'b0, 6'd5}, 64'hA0 + 64'(i), i == 3);
      step(0, 0, 0);
    end
    idle();
    step(0, 0, 0);

    // m1 read with AR and R backpressure
    m1_ar = mk_ar(6'd9, 32'h2000, 8'd1);
    m1_arvalid = 1'b1;
    s_arready = 1'b0;
    step(1, 1, 0);
    m1_arvalid = 1'b0;
    m0_ar = mk_ar(6'd1, 32'h40, 8'd0);
    m0_arvalid = 1'b1;
    repeat (3) step(0, 0, 0);
    m0_arvalid = 1'b0;
    s_arready = 1'b1;
    step(0, 0, 0);
    m1_rready = 1'b0;
    beat({1'b1, 6'd9}, 64'hB0, 1'b0);
    repeat (5) step(0, 0, 0);
    m1_rready = 1'b1;
    step(0, 0, 0);
    beat({1'b1, 6'd9}, 64'hB1, 1'b1);
    step(0, 0, 0);
    idle();
    step(0, 0, 0);

    // R beat with nothing in flight
    beat(7'h00, 64'hBAD, 1'b1);
    step(0, 0, 1);
    idle();
    step(0, 0, 0);

    // Reset with two bursts in flight
    m0_ar = mk_ar(6'd2, 32'h300, 8'd0);
    m0_arvalid = 1'b1;
    step(1, 0, 0);
    m0_arvalid = 1'b0;
    m1_ar = mk_ar(6'd3, 32'h400, 8'd0);
    m1_arvalid = 1'b1;
    step(1, 1, 0);
    do_reset();

    // Both masters requesting: round-robin alternation
    m0_ar = mk_ar(6'd10, 32'h1000, 8'd0);
    m1_ar = mk_ar(6'd20, 32'h2000, 8'd0);
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    drain(4);
    step(0, 0, 0);

    // Outstanding limit: 4 grants, stall, one rlast frees exactly one grant
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    repeat (3) step(0, 0, 0);
    beat({rt_q[0], 6'd10}, 64'hC0, 1'b1);
    step(0, 0, 0);
    idle();
    step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    drain(4);
    step(0, 0, 0);

    // Returning ID tagged for m1 while m0 is at the head
    m0_ar = mk_ar(6'd7, 32'h500, 8'd0);
    m0_arvalid = 1'b1;
    step(1, 0, 0);
    m0_arvalid = 1'b0;
    step(0, 0, 0);
    beat({1'b1, 6'd7}, 64'hE0, 1'b1);
    step(0, 0, 1);
    idle();
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
